// File: rtl/nic_fifo.sv
// Purpose: CPU<->router network interface with DEPTH-entry FIFOs in each direction; VC-phase-gated injection.
// Latency: router->CPU data readable the cycle after push; CPU write launches to router no earlier than two edges later.
// Backpressure: net_ri drops while the input FIFO is full; CPU writes to a full output FIFO are dropped.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   addr/d_in/d_out/nicEn/nicEnWR
//                               CPU register port (0 in-data, 1 in-status, 2 out-data, 3 out-status)
//   net_si/net_ri/net_di        router -> NIC packet (valid, ready, data)
//   net_so/net_ro/net_do        NIC -> router packet (valid, ready, data), registered launch
//   net_polarity                router phase; a packet launches only when its VC bit matches
//
// Optional feature macro: NIC_DROP_CNT_EN adds a 16-bit saturating dropped-write counter,
// read in the top 16 bits of out-status and cleared by reading out-status.

module nic_fifo #(
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              addr,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic                    nicEn,
    input  logic                    nicEnWR,
    input  logic                    net_si,
    output logic                    net_ri,
    input  logic [PACKET_WIDTH-1:0] net_di,
    output logic                    net_so,
    input  logic                    net_ro,
    output logic [PACKET_WIDTH-1:0] net_do,
    input  logic                    net_polarity
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Input FIFO (router -> CPU)
    logic [PACKET_WIDTH-1:0] in_mem_q [DEPTH];
    logic [PACKET_WIDTH-1:0] in_mem_d [DEPTH];
    logic [PTR_W-1:0]        in_wr_ptr_q, in_wr_ptr_d;
    logic [PTR_W-1:0]        in_rd_ptr_q, in_rd_ptr_d;
    logic [CNT_W-1:0]        in_count_q, in_count_d;

    // Output FIFO (CPU -> router)
    logic [PACKET_WIDTH-1:0] out_mem_q [DEPTH];
    logic [PACKET_WIDTH-1:0] out_mem_d [DEPTH];
    logic [PTR_W-1:0]        out_wr_ptr_q, out_wr_ptr_d;
    logic [PTR_W-1:0]        out_rd_ptr_q, out_rd_ptr_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;

    // Registered launch toward the router
    logic                    net_so_q, net_so_d;
    logic [PACKET_WIDTH-1:0] net_do_q, net_do_d;

    logic                    cpu_rd, cpu_wr;
    logic                    in_full, in_empty, out_full, out_empty;
    logic                    in_push, in_pop, out_push, launch;
    logic [PACKET_WIDTH-1:0] out_head;
    logic [PACKET_WIDTH-1:0] d_out_c;

`ifdef NIC_DROP_CNT_EN
    logic                    out_drop;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        cpu_rd    = nicEn && !nicEnWR;
        cpu_wr    = nicEn && nicEnWR;
        in_full   = (in_count_q == FULL_CNT);
        in_empty  = (in_count_q == '0);
        out_full  = (out_count_q == FULL_CNT);
        out_empty = (out_count_q == '0);
        out_head  = out_mem_q[out_rd_ptr_q];

        // Fullness is judged on the registered count, so a same-cycle pop
        // never opens room for a push in that cycle.
        in_push   = net_si && !in_full;
        in_pop    = cpu_rd && (addr == 2'd0) && !in_empty;
        out_push  = cpu_wr && (addr == 2'd2) && !out_full;
        launch    = !out_empty && net_ro && (out_head[PACKET_WIDTH-1] == net_polarity);
    end

    // Input FIFO next state
    always_comb begin
        in_mem_d    = in_mem_q;
        in_wr_ptr_d = in_wr_ptr_q;
        in_rd_ptr_d = in_rd_ptr_q;
        in_count_d  = in_count_q;
        if (in_push) begin
            in_mem_d[in_wr_ptr_q] = net_di;
            in_wr_ptr_d           = in_wr_ptr_q + 1'b1;
        end
        if (in_pop) begin
            in_rd_ptr_d = in_rd_ptr_q + 1'b1;
        end
        case ({in_push, in_pop})
            2'b10:   in_count_d = in_count_q + 1'b1;
            2'b01:   in_count_d = in_count_q - 1'b1;
            default: in_count_d = in_count_q;
        endcase
    end

    // Output FIFO next state and launch register
    always_comb begin
        out_mem_d    = out_mem_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_count_d  = out_count_q;
        net_so_d     = launch;
        net_do_d     = net_do_q;
        if (out_push) begin
            out_mem_d[out_wr_ptr_q] = d_in;
            out_wr_ptr_d            = out_wr_ptr_q + 1'b1;
        end
        if (launch) begin
            net_do_d     = out_head;
            out_rd_ptr_d = out_rd_ptr_q + 1'b1;
        end
        case ({out_push, launch})
            2'b10:   out_count_d = out_count_q + 1'b1;
            2'b01:   out_count_d = out_count_q - 1'b1;
            default: out_count_d = out_count_q;
        endcase
    end

`ifdef NIC_DROP_CNT_EN
    always_comb begin
        out_drop   = cpu_wr && (addr == 2'd2) && out_full;
        drop_cnt_d = drop_cnt_q;
        // A status read clears the counter; a drop landing in the same cycle restarts it at 1.
        if (cpu_rd && (addr == 2'd3)) begin
            drop_cnt_d = {15'd0, out_drop};
        end else if (out_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            in_mem_q     <= '{default: '0};
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_count_q   <= '0;
            out_mem_q    <= '{default: '0};
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_count_q  <= '0;
            net_so_q     <= 1'b0;
            net_do_q     <= '0;
        end else begin
            in_mem_q     <= in_mem_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_count_q   <= in_count_d;
            out_mem_q    <= out_mem_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_count_q  <= out_count_d;
            net_so_q     <= net_so_d;
            net_do_q     <= net_do_d;
        end
    end

    // CPU read mux; non-read cycles return zero.
    always_comb begin
        d_out_c = '0;
        if (cpu_rd) begin
            case (addr)
                2'd0: begin
                    if (!in_empty) begin
                        d_out_c = in_mem_q[in_rd_ptr_q];
                    end
                end
                2'd1: begin
                    d_out_c[0]       = !in_empty;
                    d_out_c[CNT_W:1] = in_count_q;
                end
                2'd3: begin
                    d_out_c[0]       = out_full;
                    d_out_c[CNT_W:1] = out_count_q;
`ifdef NIC_DROP_CNT_EN
                    d_out_c[PACKET_WIDTH-1 -: 16] = drop_cnt_q;
`endif
                end
                default: d_out_c = '0;
            endcase
        end
    end

    assign d_out  = d_out_c;
    // Outputs are forced quiet for the whole time reset is held, not just after its first edge.
    assign net_ri = !reset && !in_full;
    assign net_so = net_so_q && !reset;
    assign net_do = reset ? '0 : net_do_q;

endmodule

// File: tb/tb_nic_fifo.sv
module tb_nic_fifo;

    localparam int W = 64;
    localparam int D = 4;
`ifdef NIC_DROP_CNT_EN
    localparam logic [63:0] DROP1 = 64'h0001_0000_0000_0000;
`else
    localparam logic [63:0] DROP1 = 64'h0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic [W-1:0]  d_in;
    logic [W-1:0]  d_out;
    logic          nicEn;
    logic          nicEnWR;
    logic          net_si;
    logic          net_ri;
    logic [W-1:0]  net_di;
    logic          net_so;
    logic          net_ro;
    logic [W-1:0]  net_do;
    logic          net_polarity;

    nic_fifo #(.PACKET_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWR(nicEnWR),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Behavioural model: two queues, a registered launch, a drop counter.
    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    logic         m_so  = 1'b0;
    logic [W-1:0] m_do  = '0;
    int           m_drop = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_dout();
        logic [W-1:0] r;
        r = '0;
        if (nicEn && !nicEnWR) begin
            case (addr)
                2'd0: if (in_q.size() > 0) r = in_q[0];
                2'd1: r = (64'(in_q.size()) << 1) | 64'(in_q.size() != 0);
                2'd3: begin
                    r = (64'(out_q.size()) << 1) | 64'(out_q.size() == D);
`ifdef NIC_DROP_CNT_EN
                    r = r | (64'(m_drop) << 48);
`endif
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Model update on the active edge, from the inputs the bench is holding.
    always @(posedge clk) begin
        int  in_n, out_n;
        bit  rd, wr, pop_in, push_in, launch, push_out, drop;
        logic [W-1:0] head;
        if (reset) begin
            in_q.delete();
            out_q.delete();
            m_so   = 1'b0;
            m_do   = '0;
            m_drop = 0;
        end else begin
            in_n     = in_q.size();
            out_n    = out_q.size();
            rd       = nicEn && !nicEnWR;
            wr       = nicEn && nicEnWR;
            pop_in   = rd && addr == 2'd0 && in_n > 0;
            push_in  = net_si && in_n < D;
            launch   = 1'b0;
            head     = '0;
            if (out_n > 0) begin
                head   = out_q[0];
                launch = net_ro && (head[W-1] == net_polarity);
            end
            push_out = wr && addr == 2'd2 && out_n < D;
            drop     = wr && addr == 2'd2 && out_n == D;
            if (pop_in)   void'(in_q.pop_front());
            if (push_in)  in_q.push_back(net_di);
            if (launch)   void'(out_q.pop_front());
            if (push_out) out_q.push_back(d_in);
            m_so = launch;
            if (launch) m_do = head;
            if (rd && addr == 2'd3) m_drop = drop ? 1 : 0;
            else if (drop && m_drop < 16'hFFFF) m_drop = m_drop + 1;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("net_ri", {63'd0, net_ri}, {63'd0, (!reset && in_q.size() != D)});
            chk("net_so", {63'd0, net_so}, {63'd0, (m_so && !reset)});
            chk("net_do", net_do, reset ? '0 : m_do);
            chk("d_out",  d_out,  exp_dout());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nicEn = 0; nicEnWR = 0; addr = 0; d_in = '0;
        net_si = 0; net_di = '0;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        nicEn = 1; nicEnWR = 0; addr = a;
    endtask

    task automatic cpu_write(input logic [W-1:0] v);
        nicEn = 1; nicEnWR = 1; addr = 2'd2; d_in = v;
    endtask

    initial begin
        int pulses;
        logic [W-1:0] seen;
        reset = 1; net_ro = 0; net_polarity = 0;
        idle();
        tick();
        chk_en = 1'b1;
        tick();
        reset = 0;
        tick();

        // 1: idle after reset
        #1;
        chk("t1_ri", {63'd0, net_ri}, 64'd1);
        chk("t1_so", {63'd0, net_so}, 64'd0);
        cpu_read(2'd1); #1; chk("t1_st_in", d_out, 64'd0);
        tick();
        cpu_read(2'd3); #1; chk("t1_st_out", d_out, 64'd0);
        tick(); idle();

        // 2: fill input FIFO, read back in order, empty read does not pop
        for (int i = 1; i <= 4; i++) begin
            net_si = 1; net_di = 64'(i);
            tick();
        end
        net_si = 0; #1;
        chk("t2_ri_full", {63'd0, net_ri}, 64'd0);
        cpu_read(2'd1); #1; chk("t2_st_in", d_out, 64'h9);
        tick();
        for (int i = 1; i <= 4; i++) begin
            cpu_read(2'd0); #1;
            chk("t2_data", d_out, 64'(i));
            tick();
        end
        cpu_read(2'd0); #1; chk("t2_empty_rd", d_out, 64'd0);
        tick();
        cpu_read(2'd1); #1; chk("t2_st_after", d_out, 64'd0);
        tick(); idle();

        // 5: full input FIFO, router push and CPU pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            net_si = 1; net_di = 64'h11 + 64'(i);
            tick();
        end
        net_di = 64'h15; cpu_read(2'd0); #1;
        chk("t5_ri_full", {63'd0, net_ri}, 64'd0);
        chk("t5_head", d_out, 64'h11);
        tick();
        nicEn = 0; #1;
        chk("t5_ri_room", {63'd0, net_ri}, 64'd1);
        tick();
        net_si = 0; cpu_read(2'd1); #1;
        chk("t5_st_in", d_out, 64'h9);
        tick();
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'd0); #1;
            chk("t5_data", d_out, 64'h12 + 64'(i));
            tick();
        end
        idle();

        // 3: VC=1 packet launches only on a polarity=1 edge, exactly once
        net_ro = 1; net_polarity = 0;
        cpu_write(64'h8000_0000_0000_00AA);
        tick(); idle();
        pulses = 0; seen = '0;
        for (int i = 0; i < 6; i++) begin
            net_polarity = ~net_polarity;
            tick();
            if (net_so) begin pulses++; seen = net_do; end
        end
        chk("t3_pulses", 64'(pulses), 64'd1);
        chk("t3_do", seen, 64'h8000_0000_0000_00AA);
        cpu_read(2'd3); #1; chk("t3_st_out", d_out, 64'd0);
        tick(); idle();
        // VC=0 packet for the other phase
        cpu_write(64'h0000_0000_0000_0055);
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            net_polarity = ~net_polarity;
            tick();
        end
        chk("t3_do_vc0", net_do, 64'h55);

        // 4: overflow the output FIFO
        net_ro = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_write(64'h100 + 64'(i));
            tick();
        end
        cpu_read(2'd3); #1; chk("t4_st_drop", d_out, 64'h9 | DROP1);
        tick();
        cpu_read(2'd3); #1; chk("t4_st_clr", d_out, 64'h9);
        tick(); idle();
        net_ro = 1; net_polarity = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_do_last", net_do, 64'h103);
        cpu_read(2'd3); #1; chk("t4_st_empty", d_out, 64'd0);
        tick(); idle();

        // 6: reset with both FIFOs holding 2 and a launch in progress
        net_ro = 0;
        for (int i = 0; i < 2; i++) begin
            net_si = 1; net_di = 64'hA1 + 64'(i);
            cpu_write(64'hB1 + 64'(i));
            tick();
        end
        net_si = 0;
        net_ro = 1; net_polarity = 0;
        cpu_write(64'hB3);
        tick();
        idle(); net_ro = 0; #1;
        chk("t6_so", {63'd0, net_so}, 64'd1);
        chk("t6_do", net_do, 64'hB1);
        reset = 1;
        tick();
        chk("t6_rst_so", {63'd0, net_so}, 64'd0);
        chk("t6_rst_ri", {63'd0, net_ri}, 64'd0);
        chk("t6_rst_do", net_do, 64'd0);
        cpu_read(2'd1); #1; chk("t6_rst_st_in", d_out, 64'd0);
        cpu_read(2'd3); #1; chk("t6_rst_st_out", d_out, 64'd0);
        tick(); idle();
        reset = 0;
        tick();
        chk("t6_ri_after", {63'd0, net_ri}, 64'd1);
        chk("t6_so_after", {63'd0, net_so}, 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
